// File: rtl/snake_body_store.sv
// -----------------------------------------------------------------------------
// snake_body_store
//
// Stores the top-left (x,y) pixel coordinates of every snake segment, head at
// index 0. A move request runs a short FSM:
//   IDLE   -> accept step, resolve heading, compute the new head, check walls
//   SCAN   -> compare the new head against one body segment per cycle
//   COMMIT -> shift the body one slot toward the tail and write the new head
//   DEAD   -> sticky collision, left only through reset
// The downstream VGA draw/erase FSM reads segments through rd_idx and uses
// erase_x/erase_y to blank the tail cell vacated by the last move.
//
// Configuration macro:
//   SNAKE_WRAP_EN  defined   -> the head wraps at the screen edges, so only
//                               self collision reaches DEAD
//                  undefined -> hitting a wall reaches DEAD
//
// Ports:
//   clk          system clock (CLOCK_50)
//   reset        synchronous, active-high reset
//   step         1-cycle move request, accepted only in IDLE
//   dir[1:0]     requested heading: 00 right, 01 down, 10 up, 11 left
//   grow         sampled with step; grow by one segment on this move
//   rd_idx[3:0]  segment index for the draw FSM
//   rd_x[7:0]    x of segment rd_idx, 0 if rd_idx >= length
//   rd_y[6:0]    y of segment rd_idx, 0 if rd_idx >= length
//   length[4:0]  current segment count
//   erase_x/y    tail cell vacated by the last commit
//   erase_valid  last commit vacated a cell (non-grow move)
//   busy         high in SCAN and COMMIT
//   done         1-cycle pulse; the moved body is visible in this cycle
//   collide      sticky collision flag, high in DEAD
// -----------------------------------------------------------------------------
module snake_body_store #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int XDIM     = 10,
  parameter int YDIM     = 10,
  parameter int XSCREEN  = 160,
  parameter int YSCREEN  = 120,
  parameter int X_INIT   = 80,
  parameter int Y_INIT   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic       grow,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  output logic [4:0] length,
  output logic [7:0] erase_x,
  output logic [6:0] erase_y,
  output logic       erase_valid,
  output logic       busy,
  output logic       done,
  output logic       collide
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  // Encoding chosen so that a 180-degree reversal is the bitwise inverse.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [7:0] X_STEP = 8'(XDIM);
  localparam logic [7:0] X_MAX  = 8'(XSCREEN - XDIM);
  localparam logic [6:0] Y_STEP = 7'(YDIM);
  localparam logic [6:0] Y_MAX  = 7'(YSCREEN - YDIM);

  state_t     state, state_d;
  dir_t       cur_dir, dir_req, dir_res;

  logic [7:0] seg_x [MAX_LEN];
  logic [6:0] seg_y [MAX_LEN];

  logic [7:0] nx, nx_c;
  logic [6:0] ny, ny_c;
  logic       grow_q;
  logic [3:0] scan_i;
  logic [4:0] scan_last;
  logic       scan_at_last;
  logic       scan_match;
  logic       wall_hit;
  logic       hit_right, hit_left, hit_down, hit_up;

  // ---------------------------------------------------------------------------
  // Heading resolution and new-head computation (used only in IDLE)
  // ---------------------------------------------------------------------------
  assign dir_req = dir_t'(dir);
  assign dir_res = (dir_req == dir_t'(~cur_dir)) ? cur_dir : dir_req;

  // Sums are widened by one bit so the comparison cannot wrap.
  assign hit_right = ({1'b0, seg_x[0]} + {1'b0, X_STEP}) > {1'b0, X_MAX};
  assign hit_left  = seg_x[0] < X_STEP;
  assign hit_down  = ({1'b0, seg_y[0]} + {1'b0, Y_STEP}) > {1'b0, Y_MAX};
  assign hit_up    = seg_y[0] < Y_STEP;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nx_c     = seg_x[0];
    ny_c     = seg_y[0];
    wall_hit = 1'b0;
    case (dir_res)
      DIR_RIGHT: begin
        if (hit_right) begin
`ifdef SNAKE_WRAP_EN
          nx_c = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          nx_c = seg_x[0] + X_STEP;
        end
      end
      DIR_LEFT: begin
        if (hit_left) begin
`ifdef SNAKE_WRAP_EN
          nx_c = X_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          nx_c = seg_x[0] - X_STEP;
        end
      end
      DIR_DOWN: begin
        if (hit_down) begin
`ifdef SNAKE_WRAP_EN
          ny_c = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          ny_c = seg_y[0] + Y_STEP;
        end
      end
      default: begin  // DIR_UP
        if (hit_up) begin
`ifdef SNAKE_WRAP_EN
          ny_c = Y_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          ny_c = seg_y[0] - Y_STEP;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Self-collision scan. On a non-grow move the tail vacates, so it is skipped.
  // ---------------------------------------------------------------------------
  assign scan_last    = grow_q ? (length - 5'd1) : (length - 5'd2);
  assign scan_at_last = ({1'b0, scan_i} == scan_last);
  assign scan_match   = (seg_x[scan_i] == nx) && (seg_y[scan_i] == ny);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    collide = 1'b0;
    case (state)
      S_IDLE: begin
        if (step) state_d = wall_hit ? S_DEAD : S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (scan_match)        state_d = S_DEAD;
        else if (scan_at_last) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin  // S_DEAD
        collide = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the segment store is reset element by element because the game
  // needs a known starting body; it is a register file, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x[i] <= 8'(X_INIT - i * XDIM);
          seg_y[i] <= 7'(Y_INIT);
        end else begin
          seg_x[i] <= '0;
          seg_y[i] <= '0;
        end
      end
      length      <= 5'(INIT_LEN);
      cur_dir     <= DIR_RIGHT;
      nx          <= '0;
      ny          <= '0;
      grow_q      <= 1'b0;
      scan_i      <= '0;
      erase_x     <= '0;
      erase_y     <= '0;
      erase_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the body shift read every old
      // segment value before any of them is overwritten in this edge.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step) begin
            grow_q  <= grow;
            cur_dir <= dir_res;
            nx      <= nx_c;
            ny      <= ny_c;
            scan_i  <= '0;
          end
        end
        S_SCAN: begin
          scan_i <= scan_i + 4'd1;
        end
        S_COMMIT: begin
          erase_x     <= seg_x[4'(length - 5'd1)];
          erase_y     <= seg_y[4'(length - 5'd1)];
          erase_valid <= ~grow_q;
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          // Growing at full length degrades to a plain move.
          if (grow_q && (length < 5'(MAX_LEN))) length <= length + 5'd1;
          done <= 1'b1;
        end
        default: ;  // S_DEAD: everything holds
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: registered state only, masked beyond the live body.
  // ---------------------------------------------------------------------------
  assign rd_x = ({1'b0, rd_idx} < length) ? seg_x[rd_idx] : '0;
  assign rd_y = ({1'b0, rd_idx} < length) ? seg_y[rd_idx] : '0;

endmodule

// File: tb/tb_snake_body_store.sv
// -----------------------------------------------------------------------------
// tb_snake_body_store
//
// Directed bench for snake_body_store with default parameters. A table of
// move records (heading, grow, expected latency/head/tail/erase) is applied
// from reset, followed by hand-written sequences for busy-time steps, heading
// reversal, wall and self collision, and reset in the middle of a scan.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snake_body_store;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [1:0] dir;
  logic       grow;
  logic [3:0] rd_idx;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [4:0] length;
  logic [7:0] erase_x;
  logic [6:0] erase_y;
  logic       erase_valid;
  logic       busy;
  logic       done;
  logic       collide;

  always #5 clk = ~clk;

  snake_body_store dut (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .dir         (dir),
    .grow        (grow),
    .rd_idx      (rd_idx),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .length      (length),
    .erase_x     (erase_x),
    .erase_y     (erase_y),
    .erase_valid (erase_valid),
    .busy        (busy),
    .done        (done),
    .collide     (collide)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int ex;
    int ey;
  } rd_vec_t;

  typedef struct {
    string      name;
    logic [1:0] d;
    logic       g;
    int         lat;
    int         len;
    int         hx, hy;
    int         tx, ty;
    int         ev;
    int         ex, ey;
  } step_vec_t;

  rd_vec_t   reset_tab [6];
  step_vec_t move_tab  [5];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seg(input string name, input int idx, input int ex, input int ey);
    rd_idx = 4'(idx);
    #0.1;
    check($sformatf("%s.seg%0d.x", name, idx), int'(rd_x), ex);
    check($sformatf("%s.seg%0d.y", name, idx), int'(rd_y), ey);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step  = 1'b0;
    grow  = 1'b0;
    dir   = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    for (int i = 0; i < 6; i++)
      check_seg(name, reset_tab[i].idx, reset_tab[i].ex, reset_tab[i].ey);
    check({name, ".length"},      int'(length),      4);
    check({name, ".collide"},     int'(collide),     0);
    check({name, ".busy"},        int'(busy),        0);
    check({name, ".done"},        int'(done),        0);
    check({name, ".erase_valid"}, int'(erase_valid), 0);
    check({name, ".erase_x"},     int'(erase_x),     0);
    check({name, ".erase_y"},     int'(erase_y),     0);
  endtask

  // Pulse step for one cycle and return the cycle on which done is seen
  // (cycle 1 is the first cycle after step is sampled); 0 means timeout.
  task automatic do_step(input logic [1:0] d, input logic g, output int lat);
    step = 1'b1;
    dir  = d;
    grow = g;
    tick();
    step = 1'b0;
    grow = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  int lat;
  int coll_at;
  bit saw_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    step   = 1'b0;
    dir    = 2'b00;
    grow   = 1'b0;
    rd_idx = 4'd0;

    reset_tab[0] = '{0, 80, 30};
    reset_tab[1] = '{1, 70, 30};
    reset_tab[2] = '{2, 60, 30};
    reset_tab[3] = '{3, 50, 30};
    reset_tab[4] = '{4, 0, 0};
    reset_tab[5] = '{15, 0, 0};

    //               name        dir    grow  lat len  head     tail    ev erase
    move_tab[0] = '{"right",   2'd0, 1'b0, 5, 4,  90, 30,  60, 30, 1, 50, 30};
    move_tab[1] = '{"down_g",  2'd1, 1'b1, 6, 5,  90, 40,  60, 30, 0, 60, 30};
    move_tab[2] = '{"up_rev",  2'd2, 1'b0, 6, 5,  90, 50,  70, 30, 1, 60, 30};
    move_tab[3] = '{"left",    2'd3, 1'b0, 6, 5,  80, 50,  80, 30, 1, 70, 30};
    move_tab[4] = '{"up",      2'd2, 1'b0, 6, 5,  80, 40,  90, 30, 1, 80, 30};

    // ---- reset state ----
    do_reset();
    check_reset_state("rst");

    // ---- single right move: latency, body shift, erase, done pulse ----
    do_step(2'd0, 1'b0, lat);
    check("mv.lat", lat, 5);
    check_seg("mv", 0, 90, 30);
    check_seg("mv", 1, 80, 30);
    check_seg("mv", 2, 70, 30);
    check_seg("mv", 3, 60, 30);
    check("mv.erase_x", int'(erase_x), 50);
    check("mv.erase_y", int'(erase_y), 30);
    check("mv.erase_valid", int'(erase_valid), 1);
    tick();
    check("mv.done_pulse", int'(done), 0);

    // ---- reversal from reset is ignored: still moves right ----
    do_reset();
    do_step(2'd3, 1'b0, lat);
    check("rev.lat", lat, 5);
    check_seg("rev", 0, 90, 30);
    check_seg("rev", 1, 80, 30);

    // ---- grow, with a step issued while busy ----
    do_reset();
    step = 1'b1; dir = 2'd0; grow = 1'b1;
    tick();                                   // cycle 1
    step = 1'b0; grow = 1'b0;
    check("grow.busy", int'(busy), 1);
    tick();                                   // cycle 2
    step = 1'b1; dir = 2'd1;                  // must be ignored
    tick();                                   // cycle 3
    step = 1'b0;
    lat = 0;
    for (int n = 3; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      tick();
    end
    check("grow.lat", lat, 6);
    check("grow.length", int'(length), 5);
    check("grow.erase_valid", int'(erase_valid), 0);
    check_seg("grow", 0, 90, 30);
    check_seg("grow", 3, 60, 30);
    check_seg("grow", 4, 50, 30);
    for (int n = 0; n < 8; n++) tick();
    check("grow.idle_busy", int'(busy), 0);
    check_seg("grow_hold", 0, 90, 30);
    check("grow_hold.length", int'(length), 5);

    // ---- table-driven move sequence from reset ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_step(move_tab[i].d, move_tab[i].g, lat);
      check({move_tab[i].name, ".lat"}, lat, move_tab[i].lat);
      check({move_tab[i].name, ".length"}, int'(length), move_tab[i].len);
      check_seg(move_tab[i].name, 0, move_tab[i].hx, move_tab[i].hy);
      check_seg(move_tab[i].name, move_tab[i].len - 1, move_tab[i].tx, move_tab[i].ty);
      check_seg(move_tab[i].name, move_tab[i].len, 0, 0);
      check({move_tab[i].name, ".erase_valid"}, int'(erase_valid), move_tab[i].ev);
      check({move_tab[i].name, ".erase_x"}, int'(erase_x), move_tab[i].ex);
      check({move_tab[i].name, ".erase_y"}, int'(erase_y), move_tab[i].ey);
      check({move_tab[i].name, ".collide"}, int'(collide), 0);
      tick();
    end

    // ---- self collision: grow right, then down, left, up onto seg3 ----
    do_reset();
    do_step(2'd0, 1'b1, lat);
    do_step(2'd1, 1'b0, lat);
    do_step(2'd3, 1'b0, lat);
    check_seg("self_pre", 0, 80, 40);
    check_seg("self_pre", 3, 80, 30);
    step = 1'b1; dir = 2'd2;
    tick();
    step = 1'b0;
    coll_at  = 0;
    saw_done = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done) saw_done = 1'b1;
      if (collide) begin
        coll_at = n;
        break;
      end
      tick();
    end
    check("self.collide_cycle", coll_at, 5);
    check("self.no_done", int'(saw_done), 0);
    check("self.busy", int'(busy), 0);
    check("self.length", int'(length), 5);
    check_seg("self", 0, 80, 40);
    step = 1'b1; dir = 2'd0;
    tick();
    step = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    check("self_dead.collide", int'(collide), 1);
    check_seg("self_dead", 0, 80, 40);
    do_reset();
    check_reset_state("self_rst");

    // ---- wall: drive head to x=150, then step right ----
    do_reset();
    for (int i = 0; i < 7; i++) do_step(2'd0, 1'b0, lat);
    check("wall_pre.lat", lat, 5);
    check_seg("wall_pre", 0, 150, 30);
    tick();
    step = 1'b1; dir = 2'd0;
    tick();
    step = 1'b0;
`ifdef SNAKE_WRAP_EN
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      tick();
    end
    check("wrap.lat", lat, 5);
    check("wrap.collide", int'(collide), 0);
    check_seg("wrap", 0, 0, 30);
    check_seg("wrap", 1, 150, 30);
`else
    check("wall.collide", int'(collide), 1);
    check("wall.busy", int'(busy), 0);
    check_seg("wall", 0, 150, 30);
    check_seg("wall", 1, 140, 30);
    check("wall.length", int'(length), 4);
    check("wall.erase_x", int'(erase_x), 110);
    check("wall.erase_valid", int'(erase_valid), 1);
    step = 1'b1; dir = 2'd1;
    tick();
    step = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    check("wall_dead.collide", int'(collide), 1);
    check_seg("wall_dead", 0, 150, 30);
`endif

    // ---- reset in the middle of a scan ----
    do_reset();
    step = 1'b1; dir = 2'd1;
    tick();
    step = 1'b0;
    tick();
    check("midscan.busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midscan_rst");
    for (int n = 0; n < 8; n++) tick();
    check("midscan_after.done", int'(done), 0);
    check_seg("midscan_after", 0, 80, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
